// File: rtl/mfi_ram_arb_if.sv
// Port bundle for the MFi descriptor BRAM arbiter: stream request,
// byte stream, config access and the shared BRAM port.
interface mfi_ram_arb_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              done;
  logic              cfg_req;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_ack;
  logic [DATA_W-1:0] cfg_rdata;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req_valid, req_addr, req_len,
    input  m_ready,
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
    input  ram_dout,
    output req_ready, m_valid, m_data, m_last, done,
    output cfg_ack, cfg_rdata,
    output ram_ce, ram_oce, ram_wre, ram_ad, ram_din
  );

  modport master (
    output req_valid, req_addr, req_len,
    output m_ready,
    output cfg_req, cfg_we, cfg_addr, cfg_wdata,
    output ram_dout,
    input  req_ready, m_valid, m_data, m_last, done,
    input  cfg_ack, cfg_rdata,
    input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din
  );
endinterface

// File: rtl/mfi_ram_arb.sv
// Arbiter/controller sharing one BRAM port between a descriptor
// streamer and a byte-wide config port, with a 2-entry skid FIFO.
module mfi_ram_arb #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
) (
  input logic          clk,
  input logic          rst_n,
  mfi_ram_arb_if.slave bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [DATA_W-1:0] fifo_d [2];
  logic [1:0]        fifo_l;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              rd_fly, rd_fly_last;
  logic              cfg_rd_fly, ack, done_q;
  logic              last_grant;
  logic [DATA_W-1:0] rdata_q;

  logic              accept, s_elig, c_elig;
  logic              s_gnt, c_gnt;
  logic              head_v, head_l, hs;
  logic [DATA_W-1:0] head_d;
  logic              push, pop, fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    s_elig   = 1'b0;
    c_elig   = 1'b0;
    s_gnt    = 1'b0;
    c_gnt    = 1'b0;
    head_v   = 1'b0;
    head_l   = 1'b0;
    head_d   = '0;
    hs       = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    fin      = 1'b0;

    accept = (state == IDLE) && bus.req_valid;
    s_elig = (state == STREAM) && (rem != '0) &&
             (({1'b0, count} + {2'b0, rd_fly}) < 3'd2);
    c_elig = rst_n && bus.cfg_req && !ack;
    // on contention the side that did not win last time goes first
    s_gnt  = s_elig && (!c_elig || last_grant);
    c_gnt  = c_elig && !s_gnt;

    // an empty FIFO lets the in-flight read bypass straight to the head
    head_v = (count != 2'd0) || rd_fly;
    if (count != 2'd0) begin
      head_d = fifo_d[rd_ptr];
      head_l = fifo_l[rd_ptr];
    end else if (rd_fly) begin
      head_d = bus.ram_dout;
      head_l = rd_fly_last;
    end
    hs   = head_v && bus.m_ready;
    pop  = hs && (count != 2'd0);
    push = rd_fly && !(hs && (count == 2'd0));
    fin  = hs && head_l;

    unique case (1'b1)
      state == IDLE:
        if (accept && (bus.req_len != '0)) state_nx = STREAM;
      state == STREAM:
        if (fin) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      rem         <= '0;
      fifo_d[0]   <= '0;
      fifo_d[1]   <= '0;
      fifo_l      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      rd_fly      <= 1'b0;
      rd_fly_last <= 1'b0;
      cfg_rd_fly  <= 1'b0;
      ack         <= 1'b0;
      done_q      <= 1'b0;
      last_grant  <= 1'b1;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        addr <= bus.req_addr;
        rem  <= bus.req_len;
      end else if (s_gnt) begin
        addr <= addr + 1'b1;
        rem  <= rem - 1'b1;
      end
      rd_fly      <= s_gnt;
      rd_fly_last <= s_gnt && (rem == LEN_W'(1));
      if (push) begin
        fifo_d[wr_ptr] <= bus.ram_dout;
        fifo_l[wr_ptr] <= rd_fly_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count      <= count + {1'b0, push} - {1'b0, pop};
      ack        <= c_gnt;
      cfg_rd_fly <= c_gnt && !bus.cfg_we;
      if (cfg_rd_fly) rdata_q <= bus.ram_dout;
      done_q <= (accept && (bus.req_len == '0)) || fin;
      if (s_gnt)      last_grant <= 1'b0;
      else if (c_gnt) last_grant <= 1'b1;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.m_valid   = head_v;
  assign bus.m_data    = head_d;
  assign bus.m_last    = head_l;
  assign bus.done      = done_q;
  assign bus.cfg_ack   = ack;
  assign bus.cfg_rdata = cfg_rd_fly ? bus.ram_dout : rdata_q;
  assign bus.ram_ce    = s_gnt || c_gnt;
  assign bus.ram_oce   = 1'b1;
  assign bus.ram_wre   = c_gnt && bus.cfg_we;
  assign bus.ram_ad    = s_gnt ? addr :
                         (c_gnt ? bus.cfg_addr : '0);
  assign bus.ram_din   = (c_gnt && bus.cfg_we) ? bus.cfg_wdata : '0;

endmodule

// File: tb/tb_mfi_ram_arb.sv
// Directed bench for mfi_ram_arb with a behavioural 2048x8 BRAM
// and a bench-owned reference copy of its contents.
module tb_mfi_ram_arb;

  logic clk;
  logic rst_n;

  mfi_ram_arb_if bus ();

  mfi_ram_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem     [2048];
  logic [7:0] ref_mem [2048];
  logic [7:0] got [$];

  int checks;
  int errors;
  int first_v, done_c, last_c, ndone;
  int lastcnt, lastidx, viol, nack;
  bit any_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_din;
      else             bus.ram_dout   <= mem[bus.ram_ad];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_stream(input logic [10:0] a,
                            input logic [11:0] n,
                            input bit rnd,
                            input bit cfg_on,
                            input int budget);
    bit pv, pr, pl, last_hs, s_prev, s_g;
    logic [7:0] pd;
    logic [10:0] ix;
    got.delete();
    first_v = -1; done_c = -1; last_c = -1; ndone = 0;
    lastcnt = 0; lastidx = -1; viol = 0; nack = 0; any_v = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; last_hs = 0; s_prev = 0;
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = n;
    bus.m_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cfg_on) begin
      bus.cfg_req  = 1'b1;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = 11'h010;
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (last_hs) chk("done_after_last", bus.done, 1);
      last_hs = 0;
      if (pv && !pr) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, pd);
        chk("hold_last", bus.m_last, pl);
      end
      if (cfg_on && bus.cfg_ack) begin
        nack++;
        chk("cfg_rd_during_stream", bus.cfg_rdata, ref_mem[16]);
      end
      s_g = bus.ram_ce && !bus.ram_wre && (bus.ram_ad != 11'h010);
      if (cfg_on && s_g && s_prev) viol++;
      s_prev = s_g;
      if (bus.m_valid) any_v = 1;
      if (bus.m_valid && first_v < 0) first_v = c;
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        if (bus.m_last) begin
          lastcnt++;
          lastidx = got.size() - 1;
          last_c  = c;
          last_hs = 1;
        end
      end
      pv = bus.m_valid; pr = bus.m_ready;
      pd = bus.m_data;  pl = bus.m_last;
      if (done_c >= 0 && (!cfg_on || bus.cfg_ack)) begin
        bus.cfg_req = 1'b0;
        break;
      end
    end
    bus.cfg_req = 1'b0;
    chk("done_seen", done_c >= 0, 1);
    repeat (2) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.m_valid) any_v = 1;
    end
    chk("done_pulses", ndone, 1);
    chk("byte_count", got.size(), 32'(n));
    chk("last_count", lastcnt, (n != 0) ? 1 : 0);
    if (n != 0) chk("last_index", lastidx, 32'(n) - 1);
    for (int i = 0; i < got.size() && i < int'(n); i++) begin
      ix = a + 11'(i);
      chk("data", got[i], ref_mem[ix]);
    end
  endtask

  task automatic cfg_op(input bit we,
                        input logic [10:0] a,
                        input logic [7:0] wd,
                        output logic [7:0] rd);
    int lat;
    lat = -1;
    rd  = 'x;
    @(negedge clk);
    bus.cfg_req   = 1'b1;
    bus.cfg_we    = we;
    bus.cfg_addr  = a;
    bus.cfg_wdata = wd;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin
        lat = c;
        rd  = bus.cfg_rdata;
        break;
      end
    end
    bus.cfg_req = 1'b0;
    if (we) ref_mem[a] = wd;
    chk("cfg_ack_latency", lat, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] e_a [4];
    logic [7:0] e_b [4];
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    ref_mem[0]     = 8'hFF;
    ref_mem[1]     = 8'h55;
    ref_mem[2]     = 8'h02;
    ref_mem[3]     = 8'h00;
    ref_mem[11'h7FE] = 8'hFF;
    ref_mem[11'h7FF] = 8'hFF;
    for (int i = 0; i < 2048; i++) mem[i] = ref_mem[i];
    e_a = '{8'hFF, 8'h55, 8'h02, 8'h00};
    e_b = '{8'hFF, 8'hFF, 8'hFF, 8'h55};

    bus.ram_dout  = '0;
    bus.req_valid = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.m_ready   = 0;
    bus.cfg_req   = 0; bus.cfg_we = 0;
    bus.cfg_addr  = '0; bus.cfg_wdata = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_ack", bus.cfg_ack, 0);
    chk("rst_ram_ce", bus.ram_ce, 0);
    chk("rst_ram_wre", bus.ram_wre, 0);
    chk("rst_ram_ad", bus.ram_ad, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    chk("rst_cfg_rdata", bus.cfg_rdata, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_ram_oce", bus.ram_oce, 1);
    chk("rst_req_ready", bus.req_ready, 1);
    rst_n = 1;

    run_stream(11'h000, 12'd4, 0, 0, 40);
    for (int i = 0; i < 4; i++) chk("t1_byte", got[i], e_a[i]);
    chk("t1_first_valid", first_v, 2);
    chk("t1_last_beat", last_c, 5);
    chk("t1_done_cycle", done_c, 6);

    run_stream(11'h7FE, 12'd4, 0, 0, 40);
    for (int i = 0; i < 4; i++) chk("t2_wrap_byte", got[i], e_b[i]);

    run_stream(11'h000, 12'd32, 1, 0, 400);

    cfg_op(1, 11'h004, 8'hA5, rd);
    cfg_op(0, 11'h004, 8'h00, rd);
    chk("t4_cfg_rdata", rd, 8'hA5);
    run_stream(11'h004, 12'd1, 0, 0, 40);
    chk("t4_stream_byte", got[0], 8'hA5);

    run_stream(11'h020, 12'd16, 0, 1, 80);
    chk("t5_done_bound", done_c <= 35, 1);
    chk("t5_alternate", viol, 0);
    chk("t5_cfg_acks", nack >= 8, 1);

    run_stream(11'h000, 12'd0, 0, 0, 10);
    chk("t6_len0_no_valid", any_v, 0);
    chk("t6_len0_done_cycle", done_c, 1);

    @(negedge clk);
    bus.req_valid = 1; bus.req_addr = 11'h000; bus.req_len = 12'd100;
    bus.m_ready = 0;
    @(negedge clk);
    bus.req_valid = 0;
    repeat (3) @(negedge clk);
    chk("t6_stalled_valid", bus.m_valid, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_m_valid", bus.m_valid, 0);
    chk("t6_rst_m_data", bus.m_data, 0);
    chk("t6_rst_ram_ce", bus.ram_ce, 0);
    chk("t6_rst_req_ready", bus.req_ready, 1);
    @(negedge clk);
    chk("t6_rst_done", bus.done, 0);
    rst_n = 1;
    bus.m_ready = 1;
    run_stream(11'h000, 12'd2, 0, 0, 40);
    chk("t6_after_b0", got[0], 8'hFF);
    chk("t6_after_b1", got[1], 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
